pat_flow_ctl: RTL and testbench

Parametrised program-flow controller for the pat pattern processor. It owns the program counter and a hardware call/return stack, and executes forward/backward relative branches, absolute calls, returns, stalls and synchronous restarts. It replaces the purely combinational next-PC logic with a registered unit that has configurable address width, offset width and stack depth, plus full/empty status and optional sticky stack-error detection. The decoder drives one-hot op strobes; the instruction-memory address is taken from `pc`.

---
 rtl/pat_flow_ctl_if.sv | 42 ++++
 rtl/pat_flow_ctl.sv | 141 ++++++++++++++
 tb/tb_pat_flow_ctl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pat_flow_ctl_if.sv
// pat_flow_ctl_if: decoder <-> flow-controller bundle.
// master = decoder side, slave = pat_flow_ctl.
interface pat_flow_ctl_if #(
    parameter int I_ADR_WIDTH  = 10,
    parameter int OFFSET_WIDTH = 8,
    parameter int SP_WIDTH     = 4
);
    logic                    en;
    logic                    restart;
    logic [I_ADR_WIDTH-1:0]  restart_adr;
    logic                    op_bf;
    logic                    op_bb;
    logic                    op_call;
    logic                    op_return;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [I_ADR_WIDTH-1:0]  call_target;
    logic [I_ADR_WIDTH-1:0]  pc;
    logic [I_ADR_WIDTH-1:0]  ret_adr;
    logic [SP_WIDTH-1:0]     sp;
    logic                    stack_empty;
    logic                    stack_full;
    logic                    err_overflow;
    logic                    err_underflow;

    modport master (
        output en, restart, restart_adr,
        output op_bf, op_bb, op_call, op_return,
        output offset, call_target,
        input  pc, ret_adr, sp,
        input  stack_empty, stack_full,
        input  err_overflow, err_underflow
    );

    modport slave (
        input  en, restart, restart_adr,
        input  op_bf, op_bb, op_call, op_return,
        input  offset, call_target,
        output pc, ret_adr, sp,
        output stack_empty, stack_full,
        output err_overflow, err_underflow
    );
endinterface

// File: rtl/pat_flow_ctl.sv
// pat_flow_ctl: registered PC with hardware call/return stack.
// Optional macro PAT_STACK_CHECK_EN: sticky overflow/underflow detection.
module pat_flow_ctl #(
    parameter int I_ADR_WIDTH  = 10,
    parameter int OFFSET_WIDTH = 8,
    parameter int STACK_DEPTH  = 8,
    parameter int SP_WIDTH     = 4
) (
    input logic          clk,
    input logic          reset,
    pat_flow_ctl_if.slave bus
);
    localparam int IDX_W = SP_WIDTH - 1;

    logic [I_ADR_WIDTH-1:0] pc_q, pc_d;
    logic [SP_WIDTH-1:0]    sp_q, sp_d;
    logic [I_ADR_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic                   push_we;
    logic [IDX_W-1:0]       push_idx;
    logic [IDX_W-1:0]       top_idx;
    logic [I_ADR_WIDTH-1:0] pc_inc;
    logic [I_ADR_WIDTH-1:0] off_ext;
    logic                   empty;
    logic                   full;

    // sp == STACK_DEPTH wraps the low bits to 0, so top_idx lands on DEPTH-1
    assign top_idx = sp_q[IDX_W-1:0] - IDX_W'(1);
    assign pc_inc  = pc_q + I_ADR_WIDTH'(1);
    assign off_ext = I_ADR_WIDTH'(bus.offset);
    assign empty   = (sp_q == '0);
    assign full    = (sp_q == SP_WIDTH'(STACK_DEPTH));

`ifdef PAT_STACK_CHECK_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;
`endif

    // Next-state selection: restart > hold > return > call > bb > bf > inc
    always_comb begin
        pc_d     = pc_q;
        sp_d     = sp_q;
        push_we  = 1'b0;
        push_idx = sp_q[IDX_W-1:0];
`ifdef PAT_STACK_CHECK_EN
        ovf_d    = ovf_q;
        udf_d    = udf_q;
`endif
        if (bus.restart) begin
            pc_d  = bus.restart_adr;
            sp_d  = '0;
`ifdef PAT_STACK_CHECK_EN
            ovf_d = 1'b0;
            udf_d = 1'b0;
`endif
        end else if (!bus.en) begin
            pc_d = pc_q;
        end else if (bus.op_return) begin
            if (!empty) begin
                pc_d = stack_q[top_idx];
                sp_d = sp_q - SP_WIDTH'(1);
            end else begin
`ifdef PAT_STACK_CHECK_EN
                pc_d  = pc_inc;
                udf_d = 1'b1;
`else
                pc_d = stack_q[0];
`endif
            end
        end else if (bus.op_call) begin
            if (!full) begin
                push_we = 1'b1;
                sp_d    = sp_q + SP_WIDTH'(1);
                pc_d    = bus.call_target;
            end else begin
`ifdef PAT_STACK_CHECK_EN
                pc_d  = pc_inc;
                ovf_d = 1'b1;
`else
                push_we  = 1'b1;
                push_idx = '1;
                pc_d     = bus.call_target;
`endif
            end
        end else if (bus.op_bb) begin
            pc_d = pc_q - off_ext;
        end else if (bus.op_bf) begin
            pc_d = pc_q + off_ext;
        end else begin
            pc_d = pc_inc;
        end
    end

    // PC and stack-pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
            sp_q <= '0;
        end else begin
            pc_q <= pc_d;
            sp_q <= sp_d;
        end
    end

    // Stack storage; restart deliberately leaves contents intact
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (push_we) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

`ifdef PAT_STACK_CHECK_EN
    // Sticky error flags, cleared only by reset or restart
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = udf_q;
`else
    assign bus.err_overflow  = 1'b0;
    assign bus.err_underflow = 1'b0;
`endif

    assign bus.pc          = pc_q;
    assign bus.sp          = sp_q;
    assign bus.stack_empty = empty;
    assign bus.stack_full  = full;
    assign bus.ret_adr     = empty ? '0 : stack_q[top_idx];

endmodule

// File: tb/tb_pat_flow_ctl.sv
// tb_pat_flow_ctl: directed vector table plus hand-written
// sequences for stack overflow/underflow, stall and async reset.
module tb_pat_flow_ctl;
    localparam int AW = 10;
    localparam int OW = 8;
    localparam int SD = 8;
    localparam int SW = 4;

    typedef struct {
        logic          en;
        logic          rs;
        logic [AW-1:0] radr;
        logic          bf;
        logic          bb;
        logic          call;
        logic          ret;
        logic [OW-1:0] off;
        logic [AW-1:0] ct;
        logic [AW-1:0] epc;
        logic [SW-1:0] esp;
        logic [AW-1:0] eret;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    pat_flow_ctl_if #(.I_ADR_WIDTH(AW), .OFFSET_WIDTH(OW), .SP_WIDTH(SW)) bus ();

    pat_flow_ctl #(
        .I_ADR_WIDTH (AW),
        .OFFSET_WIDTH(OW),
        .STACK_DEPTH (SD),
        .SP_WIDTH    (SW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int en, input int rs, input int radr,
                                input int bf, input int bb, input int call,
                                input int ret, input int off, input int ct,
                                input int epc, input int esp, input int eret);
        vec_t v;
        v.en   = en[0];
        v.rs   = rs[0];
        v.radr = AW'(radr);
        v.bf   = bf[0];
        v.bb   = bb[0];
        v.call = call[0];
        v.ret  = ret[0];
        v.off  = OW'(off);
        v.ct   = AW'(ct);
        v.epc  = AW'(epc);
        v.esp  = SW'(esp);
        v.eret = AW'(eret);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.en          = v.en;
        bus.restart     = v.rs;
        bus.restart_adr = v.radr;
        bus.op_bf       = v.bf;
        bus.op_bb       = v.bb;
        bus.op_call     = v.call;
        bus.op_return   = v.ret;
        bus.offset      = v.off;
        bus.call_target = v.ct;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input int epc, input int esp,
                             input int eret);
        chk({tag, " pc"}, int'(bus.pc), epc);
        chk({tag, " sp"}, int'(bus.sp), esp);
        chk({tag, " ret_adr"}, int'(bus.ret_adr), eret);
        chk({tag, " empty"}, int'(bus.stack_empty), (esp == 0) ? 1 : 0);
        chk({tag, " full"}, int'(bus.stack_full), (esp == SD) ? 1 : 0);
    endtask

    vec_t vt [19];
    int   prev_pc;
    int   tgt;

    initial begin
        // en rs radr  bf bb cl rt off   ct     epc    sp eret
        vt[0]  = mk(1, 0, 0,     0, 0, 0, 0, 0,    0,     1,     0, 0);
        vt[1]  = mk(1, 0, 0,     0, 0, 0, 0, 0,    0,     2,     0, 0);
        vt[2]  = mk(1, 0, 0,     0, 0, 0, 0, 0,    0,     3,     0, 0);
        vt[3]  = mk(1, 0, 0,     0, 0, 0, 0, 0,    0,     4,     0, 0);
        vt[4]  = mk(1, 0, 0,     0, 0, 0, 0, 0,    0,     5,     0, 0);
        vt[5]  = mk(1, 1, 'h3F8, 0, 0, 0, 0, 0,    0,     'h3F8, 0, 0);
        vt[6]  = mk(1, 0, 0,     1, 0, 0, 0, 'h10, 0,     'h008, 0, 0);
        vt[7]  = mk(1, 0, 0,     0, 1, 0, 0, 'h09, 0,     'h3FF, 0, 0);
        vt[8]  = mk(1, 0, 0,     0, 0, 0, 0, 0,    0,     'h000, 0, 0);
        vt[9]  = mk(1, 1, 'h010, 0, 0, 0, 0, 0,    0,     'h010, 0, 0);
        vt[10] = mk(1, 0, 0,     0, 0, 1, 0, 0,    'h100, 'h100, 1, 'h011);
        vt[11] = mk(1, 0, 0,     0, 0, 1, 0, 0,    'h200, 'h200, 2, 'h101);
        vt[12] = mk(1, 0, 0,     0, 0, 0, 1, 0,    0,     'h101, 1, 'h011);
        vt[13] = mk(1, 0, 0,     0, 0, 0, 1, 0,    0,     'h011, 0, 0);
        vt[14] = mk(1, 0, 0,     1, 0, 1, 0, 5,    'h050, 'h050, 1, 'h012);
        vt[15] = mk(1, 0, 0,     0, 0, 1, 1, 0,    'h300, 'h012, 0, 0);
        vt[16] = mk(1, 0, 0,     1, 1, 0, 0, 2,    0,     'h010, 0, 0);
        vt[17] = mk(0, 0, 0,     0, 0, 1, 0, 0,    'h300, 'h010, 0, 0);
        vt[18] = mk(0, 1, 'h020, 0, 0, 1, 0, 0,    'h300, 'h020, 0, 0);

        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        chk_state("reset", 0, 0, 0);
        chk("reset err_ovf", int'(bus.err_overflow), 0);
        chk("reset err_udf", int'(bus.err_underflow), 0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            drive(vt[i]);
            cyc();
            chk_state($sformatf("vec%0d", i), int'(vt[i].epc),
                      int'(vt[i].esp), int'(vt[i].eret));
        end

        // Fill the stack with eight calls, then a ninth
        drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        chk("fill restart pc", int'(bus.pc), 0);
        prev_pc = 0;
        for (int i = 0; i < SD; i++) begin
            tgt = 'h100 + 16 * i;
            drive(mk(1, 0, 0, 0, 0, 1, 0, 0, tgt, 0, 0, 0));
            cyc();
            chk_state($sformatf("call%0d", i), tgt, i + 1, prev_pc + 1);
            prev_pc = tgt;
        end
        drive(mk(1, 0, 0, 0, 0, 1, 0, 0, 'h300, 0, 0, 0));
        cyc();
`ifdef PAT_STACK_CHECK_EN
        chk_state("call9", 'h171, SD, 'h161);
        chk("call9 err_ovf", int'(bus.err_overflow), 1);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        chk("ovf sticky pc", int'(bus.pc), 'h172);
        chk("ovf sticky", int'(bus.err_overflow), 1);
`else
        chk_state("call9", 'h300, SD, 'h171);
        chk("call9 err_ovf", int'(bus.err_overflow), 0);
`endif

        // Return on an empty stack
        drive(mk(1, 1, 'h030, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        chk_state("rs030", 'h030, 0, 0);
        chk("rs030 err_ovf", int'(bus.err_overflow), 0);
        drive(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc();
`ifdef PAT_STACK_CHECK_EN
        chk_state("uflow", 'h031, 0, 0);
        chk("uflow err_udf", int'(bus.err_underflow), 1);
`else
        chk_state("uflow", 'h001, 0, 0);
        chk("uflow err_udf", int'(bus.err_underflow), 0);
`endif
        drive(mk(1, 1, 'h040, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc();
        chk_state("rs040", 'h040, 0, 0);
        chk("rs040 err_udf", int'(bus.err_underflow), 0);

        // Stall with a call pending, one call in flight first
        drive(mk(1, 0, 0, 0, 0, 1, 0, 0, 'h080, 0, 0, 0));
        cyc();
        chk_state("pre-stall", 'h080, 1, 'h041);
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 'h300, 0, 0, 0));
            cyc();
            chk_state($sformatf("stall%0d", i), 'h080, 1, 'h041);
        end

        // Asynchronous reset mid-cycle
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_state("async", 0, 0, 0);
        #10;
        chk("async held pc", int'(bus.pc), 0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
